// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB CRC serializer.
//   crc_mode_t  - CRC selection carried in a packet descriptor
//   ser_state_t - serializer FSM state
//   CRC5/CRC16 generator polynomials and preset values
//   norm_mode() - maps the raw 2-bit mode field onto crc_mode_t (3 -> NONE)
package usb_pkg;

    typedef enum logic [1:0] {
        CRC_NONE = 2'd0,
        CRC_5    = 2'd1,
        CRC_16   = 2'd2
    } crc_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } ser_state_t;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_INIT  = 5'h1f;
    localparam logic [15:0] CRC16_INIT = 16'hffff;

    // Encoding 3 is reserved and behaves as "no CRC".
    function automatic crc_mode_t norm_mode(input logic [1:0] raw);
        crc_mode_t m;
        case (raw)
            2'd1:    m = CRC_5;
            2'd2:    m = CRC_16;
            default: m = CRC_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr: serial CRC shift register, one payload bit per enabled cycle.
//   clk, rst_b - clock, async active-low reset (register presets to all ones)
//   init       - synchronous preset to all ones (wins over en)
//   en         - shift in bit_in this cycle
//   bit_in     - payload bit
//   crc        - current (uncomplemented) remainder
module usb_crc_lfsr #(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = W'(5'h05)
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         init,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] crc
);

    logic [W-1:0] crc_q;
    logic         fb;

    assign fb  = crc_q[W-1] ^ bit_in;
    assign crc = crc_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            crc_q <= '1;
        end else if (init) begin
            crc_q <= '1;
        end else if (en) begin
            crc_q <= {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/usb_crc_serializer.sv
// usb_crc_serializer: turns a packet descriptor (PID, payload, length, CRC
// mode) into one serial stream: PID (LSB first), payload (bit 0 first), then
// the complemented CRC5/CRC16 (MSB first).
//   clk, rst_b             - clock, async active-low reset
//   in_valid/in_ready      - descriptor handshake; in_ready only in IDLE
//   in_pid/in_data/in_len/in_crc_mode - descriptor fields (len clamped)
//   out_valid/out_ready    - bit handshake; a bit moves when both are high
//   out_bit/out_last       - serial bit and end-of-packet marker
//   busy                   - packet in flight
//   dbg_state              - current FSM state
//   crc_value/crc_done     - only with USB_CRC_SNOOP_EN: transmitted CRC and a
//                            one-cycle pulse after the last bit is accepted
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; while valid is high and ready is low, the offered bit/last stay fixed.
module usb_crc_serializer
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BITS = 64,
    parameter int LEN_W         = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_pid,
    input  logic [MAX_DATA_BITS-1:0] in_data,
    input  logic [LEN_W-1:0]         in_len,
    input  logic [1:0]               in_crc_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_bit,
    output logic                     out_last,
    output logic                     busy,
`ifdef USB_CRC_SNOOP_EN
    output logic [15:0]              crc_value,
    output logic                     crc_done,
`endif
    output ser_state_t               dbg_state
);

    localparam int CW = LEN_W + 1;

    ser_state_t               state_q;
    logic [7:0]               pid_q;
    logic [MAX_DATA_BITS-1:0] data_q;
    logic [LEN_W-1:0]         len_q;
    crc_mode_t                mode_q;
    logic [CW-1:0]            cnt_q;

    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic        accept, fire;
    logic        has_crc, pid_last, data_last, crc_last;
    logic [15:0] crc_word;
    logic        crc_bit;
    logic [CW-1:0]    crc_last_idx;
    logic [LEN_W-1:0] len_clamped;

    assign accept  = in_valid && (state_q == ST_IDLE);
    assign fire    = (state_q != ST_IDLE) && out_ready;
    assign has_crc = (mode_q != CRC_NONE);

    assign len_clamped = (in_len > LEN_W'(MAX_DATA_BITS)) ? LEN_W'(MAX_DATA_BITS) : in_len;

    assign pid_last     = (cnt_q == CW'(7));
    assign data_last    = ((cnt_q + CW'(1)) == {1'b0, len_q});
    assign crc_last_idx = (mode_q == CRC_5) ? CW'(4) : CW'(15);
    assign crc_last     = (cnt_q == crc_last_idx);

    // CRC5 is left-aligned into the 16-bit word so both widths emit from bit 15
    // downwards, indexed by the CRC-phase bit counter.
    assign crc_word = (mode_q == CRC_5) ? {crc5, 11'b0} : crc16;
    assign crc_bit  = |(crc_word & (16'h8000 >> cnt_q));

    usb_crc_lfsr #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
        .clk    (clk),
        .rst_b  (rst_b),
        .init   (accept),
        .en     (fire && (state_q == ST_DATA) && (mode_q == CRC_5)),
        .bit_in (data_q[0]),
        .crc    (crc5)
    );

    usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
        .clk    (clk),
        .rst_b  (rst_b),
        .init   (accept),
        .en     (fire && (state_q == ST_DATA) && (mode_q == CRC_16)),
        .bit_in (data_q[0]),
        .crc    (crc16)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            pid_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            mode_q  <= CRC_NONE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        pid_q   <= in_pid;
                        data_q  <= in_data;
                        len_q   <= len_clamped;
                        mode_q  <= norm_mode(in_crc_mode);
                        cnt_q   <= '0;
                        state_q <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (out_ready) begin
                        pid_q <= pid_q >> 1;
                        if (pid_last) begin
                            cnt_q <= '0;
                            if (len_q != '0)  state_q <= ST_DATA;
                            else if (has_crc) state_q <= ST_CRC;
                            else              state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (out_ready) begin
                        data_q <= data_q >> 1;
                        if (data_last) begin
                            cnt_q   <= '0;
                            state_q <= has_crc ? ST_CRC : ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_CRC: begin
                    if (out_ready) begin
                        if (crc_last) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so they cannot move during a stall.
    always_comb begin
        out_bit  = 1'b0;
        out_last = 1'b0;
        case (state_q)
            ST_PID: begin
                out_bit  = pid_q[0];
                out_last = pid_last && (len_q == '0) && !has_crc;
            end
            ST_DATA: begin
                out_bit  = data_q[0];
                out_last = data_last && !has_crc;
            end
            ST_CRC: begin
                out_bit  = ~crc_bit;
                out_last = crc_last;
            end
            default: ;
        endcase
    end

    assign out_valid = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

`ifdef USB_CRC_SNOOP_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            crc_value <= '0;
            crc_done  <= 1'b0;
        end else begin
            crc_done <= fire && out_last;
            if (fire && out_last) begin
                case (mode_q)
                    CRC_5:   crc_value <= {11'b0, ~crc5};
                    CRC_16:  crc_value <= ~crc16;
                    default: crc_value <= '0;
                endcase
            end
        end
    end
`endif

endmodule
